// File: rtl/xcorr_peak_scheduler.sv
// xcorr_peak_scheduler: periodically scans every lag of every correlation pair and reports the peak delay per pair.
// Define XCORR_PEAK_ABS_EN to rank lags by |rdData| instead of signed rdData.
module xcorr_peak_scheduler #(
    parameter int NUM_BITS_XCORR    = 32,
    parameter int MAX_SAMPLES_DELAY = 11,
    parameter int NUM_XCORRS        = 6,
    parameter int NUM_SAMPLES       = 1024,
    parameter int DECIMATION        = 64,
    parameter int LAG_W  = $clog2(MAX_SAMPLES_DELAY + 1) + 1,
    parameter int PAIR_W = $clog2(NUM_XCORRS),
    parameter int IDX_W  = $clog2(2 * MAX_SAMPLES_DELAY + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             xcorrValid,
    output logic [PAIR_W-1:0]                rdPair,
    output logic [IDX_W-1:0]                 rdLag,
    input  logic signed [NUM_BITS_XCORR-1:0] rdData,
    output logic                             peakValid,
    input  logic                             peakReady,
    output logic [NUM_XCORRS*LAG_W-1:0]      peakLag,
    output logic                             busy,
    output logic                             overrun
);
    localparam int NUM_LAGS = 2 * MAX_SAMPLES_DELAY + 1;
    localparam int WARM_W   = $clog2(NUM_SAMPLES + 1);
    localparam int DEC_W    = $clog2(DECIMATION + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

    state_t                           state, state_nxt;
    logic [WARM_W-1:0]                warm_cnt;
    logic [DEC_W-1:0]                 dec_cnt;
    logic [PAIR_W-1:0]                pair;
    logic [IDX_W-1:0]                 lag;
    logic signed [NUM_BITS_XCORR-1:0] metric, best_val;
    logic [IDX_W-1:0]                 best_idx;
    logic                             warm_done, trigger, last_lag, last_addr, take;

    assign warm_done = warm_cnt == WARM_W'(NUM_SAMPLES);
    assign trigger   = xcorrValid && warm_done && dec_cnt == DEC_W'(DECIMATION - 1);
    assign last_lag  = lag == IDX_W'(NUM_LAGS - 1);
    assign last_addr = last_lag && pair == PAIR_W'(NUM_XCORRS - 1);

`ifdef XCORR_PEAK_ABS_EN
    localparam logic signed [NUM_BITS_XCORR-1:0] MAX_POS = {1'b0, {(NUM_BITS_XCORR-1){1'b1}}};
    // Most negative value has no positive twin, so it saturates to MAX_POS.
    assign metric = !rdData[NUM_BITS_XCORR-1] ? rdData : (rdData == ~MAX_POS ? MAX_POS : -rdData);
`else
    assign metric = rdData;
`endif

    // Lag 0 always seeds; later lags must be strictly greater so ties keep the lowest index.
    assign take = lag == '0 || metric > best_val;

    assign busy      = state == SEARCH;
    assign peakValid = state == HOLD;
    assign rdPair    = busy ? pair : '0;
    assign rdLag     = busy ? lag : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = trigger ? SEARCH : IDLE;
            SEARCH:  state_nxt = last_addr ? HOLD : SEARCH;
            HOLD:    state_nxt = peakReady ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= '0;
            dec_cnt  <= '0;
            pair     <= '0;
            lag      <= '0;
            best_val <= '0;
            best_idx <= '0;
            peakLag  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (xcorrValid && !warm_done)
                warm_cnt <= warm_cnt + 1'b1;
            else if (xcorrValid)
                dec_cnt <= dec_cnt == DEC_W'(DECIMATION - 1) ? '0 : dec_cnt + 1'b1;
            if (trigger && state != IDLE)
                overrun <= 1'b1;
            if (busy) begin
                lag  <= last_lag ? '0 : lag + 1'b1;
                pair <= last_addr ? '0 : (last_lag ? pair + 1'b1 : pair);
                if (take) begin
                    best_val <= metric;
                    best_idx <= lag;
                end
                if (last_lag)
                    peakLag[pair*LAG_W +: LAG_W] <= LAG_W'(take ? lag : best_idx) - LAG_W'(MAX_SAMPLES_DELAY);
            end
        end
    end
endmodule

// File: tb/tb_xcorr_peak_scheduler.sv
// tb_xcorr_peak_scheduler: table-driven peak patterns with a result scoreboard, plus warm-up, overrun and reset-abort sequences.
module tb_xcorr_peak_scheduler;
    localparam int NB = 32, MSD = 11, NX = 6, LW = 5, PW = 3, IW = 5, NL = 23, LV = NX * LW;

    logic                 clk = 0, rst = 1, xcorrValid = 0, peakReady = 1;
    logic [PW-1:0]        rdPair;
    logic [IW-1:0]        rdLag;
    logic signed [NB-1:0] rdData;
    logic                 peakValid, busy, overrun;
    logic [LV-1:0]        peakLag;

    always #5 clk = ~clk;

    xcorr_peak_scheduler #(
        .NUM_BITS_XCORR(NB), .MAX_SAMPLES_DELAY(MSD), .NUM_XCORRS(NX),
        .NUM_SAMPLES(1024), .DECIMATION(64)
    ) dut (
        .clk(clk), .rst(rst), .xcorrValid(xcorrValid), .rdPair(rdPair), .rdLag(rdLag),
        .rdData(rdData), .peakValid(peakValid), .peakReady(peakReady), .peakLag(peakLag),
        .busy(busy), .overrun(overrun)
    );

    logic signed [NB-1:0] mem [NX][NL];
    always_comb rdData = (int'(rdPair) < NX && int'(rdLag) < NL) ? mem[rdPair][rdLag] : '0;

    typedef struct {
        logic [NX-1:0] mask;
        int i0; int v0; int i1; int v1;
        int exp_lag; int exp_abs;
    } vec_t;

    int            checks = 0, errors = 0, exp_addr = 0;
    bit            busy_seen = 0;
    logic [LV-1:0] sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LV-1:0] exp_vec(input logic [NX-1:0] mask, input int lag);
        logic [LV-1:0] v;
        for (int p = 0; p < NX; p++) v[p*LW +: LW] = mask[p] ? LW'(lag) : LW'(-MSD);
        return v;
    endfunction

    function automatic int sel_exp(input vec_t e);
`ifdef XCORR_PEAK_ABS_EN
        return e.exp_abs;
`else
        return e.exp_lag;
`endif
    endfunction

    // Address sequence checker and result scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) exp_addr = 0;
        else begin
            if (busy) begin
                busy_seen = 1;
                check("rd_pair", rdPair, exp_addr / NL);
                check("rd_lag", rdLag, exp_addr % NL);
                exp_addr = exp_addr == NX * NL - 1 ? 0 : exp_addr + 1;
            end else begin
                check("rd_idle", {rdPair, rdLag}, 0);
                exp_addr = 0;
            end
            if (peakValid && peakReady) begin
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check("peak_lag", peakLag, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        xcorrValid = 1;
        tick();
        xcorrValid = 0;
    endtask

    task automatic warm(input int n);
        repeat (n) begin
            pulse();
            tick();
        end
    endtask

    task automatic until_trigger(output int n);
        n = 0;
        do begin
            pulse();
            n++;
            if (!busy) tick();
        end while (!busy && n < 70);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!peakValid && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic load(input vec_t e);
        for (int p = 0; p < NX; p++)
            for (int l = 0; l < NL; l++) mem[p][l] = '0;
        for (int p = 0; p < NX; p++)
            if (e.mask[p]) begin
                mem[p][e.i0] = e.v0;
                mem[p][e.i1] = e.v1;
            end
    endtask

    initial begin
        vec_t tbl[7];
        vec_t zero_e;
        int   n;
        tbl[0] = '{6'h3F, 15, 1000, 15, 1000, 4, 4};
        tbl[1] = '{6'h04, 3, 500, 20, 500, -8, -8};
        tbl[2] = '{6'h01, 0, -2000, 22, 1500, 11, -11};
        tbl[3] = '{6'h3F, 7, -5, 9, -3, -11, -4};
        tbl[4] = '{6'h2A, 22, 32'h7fffffff, 1, 7, 11, 11};
        tbl[5] = '{6'h02, 5, 32'h80000000, 6, 32'h7fffffff, -5, -6};
        tbl[6] = '{6'h10, 12, -1, 13, -1, -11, 1};
        zero_e = '{6'h00, 0, 0, 0, 0, -11, -11};
        load(zero_e);

        tick();
        tick();
        check("rst_valid", peakValid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rdpair", rdPair, 0);
        check("rst_rdlag", rdLag, 0);
        check("rst_peaklag", peakLag, 0);
        rst = 0;

        // Warm-up then decimation: 1024 + 63 pulses stay idle, the 64th triggers.
        warm(1024 + 63);
        check("no_early_busy", busy_seen, 0);
        sb_q.push_back(exp_vec(6'h00, 0));
        pulse();
        check("busy_after_64", busy, 1);
        wait_valid(n);
        check("valid_latency", n, 138);
        tick();
        check("valid_one_cycle", peakValid, 0);
        check("idle_after_hs", busy, 0);

        for (int i = 0; i < 7; i++) begin
            load(tbl[i]);
            sb_q.push_back(exp_vec(tbl[i].mask, sel_exp(tbl[i])));
            until_trigger(n);
            check("dec_period", n, 64);
            wait_valid(n);
            check("valid_latency", n, 138);
            tick();
            check("valid_one_cycle", peakValid, 0);
        end
        check("no_overrun_yet", overrun, 0);

        // Hold the result while a further trigger arrives in HOLD.
        peakReady = 0;
        load(tbl[0]);
        sb_q.push_back(exp_vec(6'h3F, 4));
        until_trigger(n);
        check("dec_period", n, 64);
        wait_valid(n);
        check("valid_latency", n, 138);
        load(tbl[2]);
        warm(64);
        repeat (72) tick();
        check("hold_overrun", overrun, 1);
        check("hold_valid", peakValid, 1);
        check("hold_busy", busy, 0);
        check("hold_peaklag", peakLag, exp_vec(6'h3F, 4));
        peakReady = 1;
        tick();
        check("hs_idle_valid", peakValid, 0);
        check("hs_idle_busy", busy, 0);

        // Reset in the middle of a search.
        load(tbl[1]);
        until_trigger(n);
        check("dec_period", n, 64);
        repeat (50) tick();
        rst = 1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", peakValid, 0);
        check("abort_overrun", overrun, 0);
        check("abort_rdpair", rdPair, 0);
        check("abort_rdlag", rdLag, 0);
        check("abort_peaklag", peakLag, 0);
        tick();
        rst = 0;
        busy_seen = 0;
        warm(1024 + 63);
        check("rewarm_no_busy", busy_seen, 0);
        sb_q.push_back(exp_vec(tbl[1].mask, sel_exp(tbl[1])));
        pulse();
        check("rewarm_busy", busy, 1);
        wait_valid(n);
        check("valid_latency", n, 138);
        tick();
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xcorr_peak_scheduler.md
XCORR_PEAK_SCHEDULER -- requirements
Module: xcorr_peak_scheduler

Interface
REQ-001 Parameter NUM_BITS_XCORR, 32, width of one correlation value.
REQ-002 Parameter MAX_SAMPLES_DELAY, 11, max lag; lag indices 0..2*MAX_SAMPLES_DELAY (23 lags).
REQ-003 Parameter NUM_XCORRS, 6, number of correlation pairs.
REQ-004 Parameter NUM_SAMPLES, 1024, warm-up length in xcorrValid pulses.
REQ-005 Parameter DECIMATION, 64, one search per DECIMATION xcorrValid pulses after warm-up.
REQ-006 Derived: LAG_W = $clog2(MAX_SAMPLES_DELAY+1)+1 (5); PAIR_W = $clog2(NUM_XCORRS) (3); IDX_W = $clog2(2*MAX_SAMPLES_DELAY+1) (5).
REQ-007 clk  input  1  clock.
REQ-008 rst  input  1  reset; asynchronous, active-high.
REQ-009 xcorrValid  input  1  one-cycle pulse; correlator updated its values.
REQ-010 rdPair  output  PAIR_W  pair select for external read mux.
REQ-011 rdLag  output  IDX_W  lag index select for external read mux.
REQ-012 rdData  input  NUM_BITS_XCORR  signed value at (rdPair, rdLag), combinational, same cycle.
REQ-013 peakValid  output  1  peak result available.
REQ-014 peakReady  input  1  consumer accepts result.
REQ-015 peakLag  output  NUM_XCORRS*LAG_W  signed delay per pair, pair p at bits [p*LAG_W +: LAG_W].
REQ-016 busy  output  1  high in SEARCH.
REQ-017 overrun  output  1  sticky; a trigger was dropped.

Function
REQ-018 Warm-up counter SHALL count xcorrValid pulses, saturating at NUM_SAMPLES; no trigger before saturation.
REQ-019 After warm-up, decimation counter SHALL count xcorrValid pulses 0..DECIMATION-1, wrapping; trigger on the pulse at count DECIMATION-1.
REQ-020 The pulse that saturates warm-up SHALL NOT count toward decimation; first trigger is the DECIMATION-th pulse after it.
REQ-021 FSM states IDLE, SEARCH, HOLD; IDLE->SEARCH on trigger; SEARCH->HOLD after last address; HOLD->IDLE when peakValid && peakReady.
REQ-022 Trigger at cycle T in IDLE: SEARCH from T+1; rdPair/rdLag step pair-major, lag-minor, (0,0)..(5,22), one address per cycle, T+1..T+138.
REQ-023 peakValid SHALL rise at T+139 and hold, with peakLag stable, until handshake.
REQ-024 Per pair, best SHALL be replaced only on strictly greater metric; ties keep lowest lag index; lag 0 always seeds.
REQ-025 peakLag[p] SHALL equal best index minus MAX_SAMPLES_DELAY (range -11..+11), two's complement.
REQ-026 Trigger in SEARCH or HOLD SHALL be dropped, set overrun, not disturb the current search or result; decimation counter keeps counting.
REQ-027 Trigger on the handshake cycle in HOLD SHALL be dropped (overrun set); no same-cycle restart.
REQ-028 rdPair/rdLag SHALL be 0 outside SEARCH; busy high exactly in SEARCH.

Reset
REQ-029 On rst: state IDLE, counters 0, peakValid 0, peakLag 0, busy 0, overrun 0, rdPair 0, rdLag 0.
REQ-030 rst mid-SEARCH or mid-HOLD SHALL abort; partial result discarded; warm-up restarts from 0.

Configuration
REQ-031 Macro XCORR_PEAK_ABS_EN defined: metric = |rdData|; most negative value maps to max positive (saturated).
REQ-032 Macro XCORR_PEAK_ABS_EN undefined: metric = rdData as signed.

Verification
REQ-033 1024 pulses then 63 pulses -> no busy; 64th pulse -> busy next cycle, peakValid 139 cycles after trigger.
REQ-034 rdData = 1000 at lag index 15, 0 elsewhere, all pairs; peakReady=1 -> peakLag every pair = +4, peakValid one cycle.
REQ-035 Pair 2: rdData = 500 at lag indices 3 and 20 -> peakLag[2] = -8 (lowest index wins).
REQ-036 Pair 0: -2000 at index 0, +1500 at index 22 -> ABS_EN: -11; without: +11.
REQ-037 peakReady=0 for 200 cycles, further trigger -> overrun=1, peakLag unchanged; peakReady=1 -> IDLE next cycle.
REQ-038 rst asserted at search cycle 50 -> all outputs 0 immediately; next trigger only after 1024+64 new pulses.
